// File: rtl/ysyx_24100005_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100005_pkg
//  Description : Shared types and constants for the ysyx_24100005 core and
//                its instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24100005_pkg;

    // Fetch unit control states
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ifu_state_t;

    // addi x0, x0, 0 -- presented to the core in place of a faulted fetch
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // First fetch address after reset; the core's PC register uses the same value
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

endpackage : ysyx_24100005_pkg
`default_nettype wire

// File: rtl/ysyx_24100005_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100005_ifu
//  Description : Instruction fetch unit. Holds the fetch PC, issues one word
//                read per instruction on a valid/ready bus, and presents the
//                word and its PC to the core. The next fetch address always
//                comes from the core's dnpc at handshake time.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100005_ifu
    import ysyx_24100005_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ysyx_24100005_pkg::RESET_PC,
    parameter logic [31:0] NOP      = ysyx_24100005_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    // instruction memory request/response
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    // core side
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic [31:0] dnpc
);

    ifu_state_t  state_q,      state_d;
    logic [31:0] fetch_pc_q,   fetch_pc_d;
    logic [31:0] inst_q,       inst_d;
    logic [31:0] inst_pc_q,    inst_pc_d;
    logic        inst_fault_q, inst_fault_d;
    logic        misaligned;

    // A PC that is not word aligned is never put on the bus
    assign misaligned = (fetch_pc_q[1:0] != 2'b00);

    // Next-state and output-register decode for the fetch FSM
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;
        case (state_q)
            S_REQ: begin
                if (misaligned) begin
                    // Fault locally: skip the bus and hand the core a NOP
                    state_d      = S_HOLD;
                    inst_d       = NOP;
                    inst_pc_d    = fetch_pc_q;
                    inst_fault_d = 1'b1;
                end else if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d      = S_HOLD;
                    inst_d       = mem_rsp_err ? NOP : mem_rsp_data;
                    inst_pc_d    = fetch_pc_q;
                    inst_fault_d = mem_rsp_err;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    state_d    = S_REQ;
                    fetch_pc_d = dnpc;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State and output registers, cleared asynchronously so an in-flight fetch is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
        end
    end

    // Output decode; the request is masked while reset is held
    always_comb begin
        mem_req_valid = (state_q == S_REQ) && !misaligned && !rst;
        mem_req_addr  = fetch_pc_q;
        inst_valid    = (state_q == S_HOLD);
        inst          = inst_q;
        inst_pc       = inst_pc_q;
        inst_fault    = inst_fault_q;
    end

endmodule : ysyx_24100005_ifu
`default_nettype wire

// File: tb/tb_ysyx_24100005_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_24100005_ifu
//  Description : Directed self-checking bench for the instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100005_ifu;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic [31:0] dnpc;

    int checks = 0;
    int errors = 0;

    ysyx_24100005_ifu dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_fault    (inst_fault),
        .dnpc          (dnpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request and presented instruction must never overlap
    always @(negedge clk) begin
        if (!rst) check("excl", {31'h0, mem_req_valid & inst_valid}, 32'h0);
    end

    initial begin
        rst           = 1'b1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        mem_rsp_err   = 1'b0;
        inst_ready    = 1'b0;
        dnpc          = 32'h0;

        // Reset state
        step();
        step();
        check("rst_req_valid", {31'h0, mem_req_valid}, 32'h0);
        check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_fault", {31'h0, inst_fault}, 32'h0);

        // Cycle 1: first request, accepted immediately
        rst = 1'b0;
        #1;
        check("c1_req_valid", {31'h0, mem_req_valid}, 32'h1);
        check("c1_req_addr", mem_req_addr, 32'h8000_0000);
        mem_req_ready = 1'b1;
        step();
        // Cycle 2: waiting
        mem_req_ready = 1'b0;
        check("c2_req_valid", {31'h0, mem_req_valid}, 32'h0);
        check("c2_inst_valid", {31'h0, inst_valid}, 32'h0);
        step();
        // Cycle 3: response
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0010_0093;
        step();
        // Cycle 4: instruction presented
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        check("c4_inst_valid", {31'h0, inst_valid}, 32'h1);
        check("c4_inst", inst, 32'h0010_0093);
        check("c4_inst_pc", inst_pc, 32'h8000_0000);
        check("c4_fault", {31'h0, inst_fault}, 32'h0);

        // Core stalls for 5 cycles; a stray response in HOLD is ignored
        for (int i = 0; i < 5; i++) begin
            mem_rsp_valid = (i == 2);
            mem_rsp_data  = 32'hDEAD_BEEF;
            step();
            check("stall_inst_valid", {31'h0, inst_valid}, 32'h1);
            check("stall_inst", inst, 32'h0010_0093);
            check("stall_inst_pc", inst_pc, 32'h8000_0000);
            check("stall_req_valid", {31'h0, mem_req_valid}, 32'h0);
        end
        mem_rsp_valid = 1'b0;

        // Handshake with sequential dnpc
        inst_ready = 1'b1;
        dnpc       = 32'h8000_0004;
        step();
        inst_ready = 1'b0;
        check("seq_req_valid", {31'h0, mem_req_valid}, 32'h1);
        check("seq_req_addr", mem_req_addr, 32'h8000_0004);
        check("seq_inst_valid", {31'h0, inst_valid}, 32'h0);

        // Memory back-pressure for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_req_valid", {31'h0, mem_req_valid}, 32'h1);
            check("bp_req_addr", mem_req_addr, 32'h8000_0004);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;

        // Bus error response becomes a faulting NOP
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = 1'b1;
        mem_rsp_data  = 32'h1234_5678;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        check("err_inst_valid", {31'h0, inst_valid}, 32'h1);
        check("err_inst", inst, 32'h0000_0013);
        check("err_fault", {31'h0, inst_fault}, 32'h1);
        check("err_inst_pc", inst_pc, 32'h8000_0004);

        // Jump
        inst_ready = 1'b1;
        dnpc       = 32'h8000_0100;
        step();
        inst_ready = 1'b0;
        check("jmp_req_valid", {31'h0, mem_req_valid}, 32'h1);
        check("jmp_req_addr", mem_req_addr, 32'h8000_0100);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0020_8113;
        step();
        mem_rsp_valid = 1'b0;
        check("jmp_inst", inst, 32'h0020_8113);
        check("jmp_inst_pc", inst_pc, 32'h8000_0100);
        check("jmp_fault", {31'h0, inst_fault}, 32'h0);

        // Misaligned target: no bus request, faulting NOP next cycle
        inst_ready = 1'b1;
        dnpc       = 32'h8000_0002;
        step();
        inst_ready    = 1'b0;
        mem_req_ready = 1'b1;
        check("mis_req_valid", {31'h0, mem_req_valid}, 32'h0);
        check("mis_inst_valid0", {31'h0, inst_valid}, 32'h0);
        step();
        mem_req_ready = 1'b0;
        check("mis_inst_valid", {31'h0, inst_valid}, 32'h1);
        check("mis_inst", inst, 32'h0000_0013);
        check("mis_fault", {31'h0, inst_fault}, 32'h1);
        check("mis_inst_pc", inst_pc, 32'h8000_0002);
        check("mis_req_valid1", {31'h0, mem_req_valid}, 32'h0);

        // Fetch to 0x80000008, then reset while waiting for the response
        inst_ready = 1'b1;
        dnpc       = 32'h8000_0008;
        step();
        inst_ready = 1'b0;
        check("pre_rst_addr", mem_req_addr, 32'h8000_0008);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_req_valid", {31'h0, mem_req_valid}, 32'h0);
        check("arst_inst_valid", {31'h0, inst_valid}, 32'h0);
        check("arst_inst", inst, 32'h0);
        check("arst_fault", {31'h0, inst_fault}, 32'h0);
        step();
        rst = 1'b0;
        // Stale response arrives after reset release and must be dropped
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hBAD0_BAD0;
        #1;
        check("post_rst_req_valid", {31'h0, mem_req_valid}, 32'h1);
        check("post_rst_req_addr", mem_req_addr, 32'h8000_0000);
        step();
        mem_rsp_valid = 1'b0;
        check("stale_inst_valid", {31'h0, inst_valid}, 32'h0);
        check("stale_req_valid", {31'h0, mem_req_valid}, 32'h1);
        check("stale_req_addr", mem_req_addr, 32'h8000_0000);
        check("stale_inst", inst, 32'h0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0297;
        step();
        mem_rsp_valid = 1'b0;
        check("fresh_inst_valid", {31'h0, inst_valid}, 32'h1);
        check("fresh_inst", inst, 32'h0000_0297);
        check("fresh_inst_pc", inst_pc, 32'h8000_0000);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ysyx_24100005_ifu
`default_nettype wire

// File: doc/ysyx_24100005_ifu.md
# ysyx_24100005_ifu

Instruction fetch unit, directly upstream of the single-cycle execute core (`ysyx_24100005_top`), which it feeds through `inst`. It holds the fetch PC, issues one word read per instruction on a valid/ready request/response memory bus, and presents the returned word plus its PC to the core with a valid/ready handshake. The core returns the dynamic next PC at handshake time, and the IFU fetches from that PC next. One fetch is outstanding at a time, with no prediction and no prefetch.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.
- `NOP`, 32'h0000_0013: word substituted on a fault (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_req_valid`  out  1  fetch request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_addr`  out  32  word address, equal to `fetch_pc`.
- `mem_rsp_valid`  in  1  response valid.
- `mem_rsp_data`  in  32  instruction word.
- `mem_rsp_err`  in  1  bus error on this response.
- `inst_valid`  out  1  `inst` and `inst_pc` are valid.
- `inst_ready`  in  1  core consumes the instruction this cycle.
- `inst`  out  32  instruction word.
- `inst_pc`  out  32  PC of `inst`.
- `inst_fault`  out  1  1 means the fetch faulted and `inst` = NOP.
- `dnpc`  in  32  next PC from the core; sampled only when `inst_valid & inst_ready`.

## Operation
- Registers:
  - `fetch_pc`: 32 bits.
  - `state`: one of S_REQ, S_WAIT, S_HOLD.
  - Output registers: `inst`, `inst_pc`, `inst_fault`.
- S_REQ:
  - `mem_req_valid`=1 and `mem_req_addr`=`fetch_pc`.
  - On `mem_req_ready`, go to S_WAIT.
  - If `fetch_pc[1:0]` != 0, no request is issued. Go directly to S_HOLD with `inst`=NOP, `inst_fault`=1, `inst_pc`=`fetch_pc`.
- S_WAIT:
  - `mem_req_valid`=0.
  - On `mem_rsp_valid`, capture `inst` = `mem_rsp_err` ? NOP : `mem_rsp_data`, `inst_fault`=`mem_rsp_err`, `inst_pc`=`fetch_pc`. Go to S_HOLD.
- S_HOLD:
  - `inst_valid`=1, and outputs hold stable until the handshake.
  - On `inst_ready`: `fetch_pc` <= `dnpc`, go to S_REQ.
- `mem_rsp_valid` outside S_WAIT is ignored; the bus guarantees at most one response per accepted request.
- No internal PC arithmetic. The next address always comes from `dnpc`, including sequential flow (`dnpc` = `inst_pc`+4).

## Timing
- Reset values:
  - `state`=S_REQ, `fetch_pc`=RESET_PC.
  - `inst`=0, `inst_pc`=0, `inst_fault`=0, `inst_valid`=0.
  - `mem_req_valid`=1 from the first cycle `rst` is low; it is 0 while `rst` is high.
- `mem_req_valid` and `mem_req_addr` stay stable from assertion until `mem_req_ready` is seen.
- Response arrives at least 1 cycle after acceptance.
- Latency:
  - `inst_valid` rises the cycle after `mem_rsp_valid`.
  - The next request is asserted the cycle after the `inst_ready` handshake.
  - Best case is 3 cycles per instruction (REQ accepted, WAIT with rsp, HOLD with ready).
- Misaligned PC: `inst_valid` is asserted 1 cycle after entering S_REQ, with no bus traffic.
- `inst_ready` without `inst_valid` has no effect.
- `mem_req_valid` and `inst_valid` are never high in the same cycle.
- Reset mid-fetch: state is cleared immediately and an in-flight response is dropped. The memory side must also be reset; no request is re-issued for the lost fetch.
- `dnpc` may be any 32-bit value; there is no wrap check, and 0xFFFF_FFFC+4 is the core's concern.

## Structure
- Shared package `ysyx_24100005_pkg`:
  - `ifu_state_t` enum: S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2.
  - `NOP_INST` constant.
  - `RESET_PC` constant, shared with the core's PC register.
- No sub-module. The FSM and the output registers are inline in one always block with async reset, plus a combinational output decode.

## Test plan
- Reset release, then memory ready=1 with 2-cycle latency returning 0x00100093 → request addr 0x80000000 on the first cycle; `inst`=0x00100093, `inst_pc`=0x80000000, `inst_valid` on cycle 4.
- Core holds `inst_ready`=0 for 5 cycles → `inst` and `inst_pc` stay stable with `inst_valid`=1 and no new request. Then ready with `dnpc`=0x80000004 → next request addr 0x80000004 one cycle later.
- Jump: `dnpc`=0x80000100 at handshake → next `mem_req_addr`=0x80000100.
- `mem_req_ready` low for 3 cycles → addr held at 0x80000004 and valid held high throughout.
- `mem_rsp_err`=1 → `inst`=0x00000013, `inst_fault`=1. `dnpc`=0x80000002 → no bus request; NOP with fault presented the next cycle.
- `rst` pulsed during S_WAIT, then a stale response arrives → response ignored; a fresh request to 0x80000000 is issued.
